// File: rtl/regfile_mp_scoreboard.sv
// Purpose: multi-port register file with a per-register busy scoreboard and optional write-through bypass.
// Latency: writes and busy updates land at the next clk edge; rdata/rbusy/rsv_conflict/busy_count are combinational.
// Backpressure: none inside; rsv_conflict reports a WAW hazard and issue logic decides whether to stall.
module regfile_mp_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_conflict,
    input  logic                flush,
    output logic [AW:0]         busy_count
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NWR-1:0]  wr_ok;
    logic            rsv_ok;

    // Qualify write ports and the reserve: register 0 is inert when it is the hardwired zero.
    always_comb begin
        wr_ok  = '0;
        rsv_ok = rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j] = we[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0));
        end
    end

    // Data array: later ports are applied last so the highest-index port wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j]) begin
                    regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Busy next state, lowest priority first: writeback clears, reserve sets, flush clears everything.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j]) begin
                busy_nxt[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Read ports: registered state, overridden by the winning same-cycle write when bypass is enabled.
    always_comb begin : read_mux
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = raddr[i*AW +: AW];
            rd = regs[ra];
            rb = busy[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_ok[j] && (waddr[j*AW +: AW] == ra)) begin
                        rd = wdata[j*XLEN +: XLEN];
                        rb = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
                rb = 1'b0;
            end
            rdata[i*XLEN +: XLEN] = rd;
            rbusy[i]              = rb;
        end
    end

    // WAW hazard uses the registered busy bit only; a same-cycle writeback does not hide it.
    always_comb begin
        rsv_conflict = rsv_ok && busy[rsv_addr];
    end

    // Popcount of outstanding reservations.
    always_comb begin
        busy_count = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_count = busy_count + {{AW{1'b0}}, busy[r]};
        end
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: an integer file (zero reg, bypass) and an FP file (no zero reg, no bypass)
// share one stimulus stream; both are compared every cycle against a behavioural model, plus directed literals.
module tb_regfile_mp_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 3;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic [NRD*AW-1:0]   raddr;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                flush;

    logic [NRD*XLEN-1:0] rdata        [2];
    logic [NRD-1:0]      rbusy        [2];
    logic                rsv_conflict [2];
    logic [AW:0]         busy_count   [2];

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) u_int (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata[0]), .rbusy(rbusy[0]),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_conflict(rsv_conflict[0]), .flush(flush), .busy_count(busy_count[0])
    );

    regfile_mp_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(0), .BYPASS(0)) u_fp (
        .clk(clk), .rstn(rstn), .raddr(raddr), .rdata(rdata[1]), .rbusy(rbusy[1]),
        .we(we), .waddr(waddr), .wdata(wdata), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rsv_conflict(rsv_conflict[1]), .flush(flush), .busy_count(busy_count[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              zr  [2] = '{1, 0};
    int              byp [2] = '{1, 0};
    logic [XLEN-1:0] m_regs [2][NREG];
    bit              m_busy [2][NREG];
    bit              m_valid = 1'b0;

    // Which write port (if any) lands on address a this cycle; highest index wins.
    function automatic int win_port(int c, logic [AW-1:0] a);
        if (zr[c] != 0 && a == 0) return -1;
        for (int j = NWR - 1; j >= 0; j--) begin
            if (we[j] && waddr[j*AW +: AW] == a) return j;
        end
        return -1;
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(int c, int i);
        logic [AW-1:0] a = raddr[i*AW +: AW];
        int p = win_port(c, a);
        if (zr[c] != 0 && a == 0) return '0;
        if (byp[c] != 0 && p >= 0) return wdata[p*XLEN +: XLEN];
        return m_regs[c][a];
    endfunction

    function automatic logic exp_rbusy(int c, int i);
        logic [AW-1:0] a = raddr[i*AW +: AW];
        if (zr[c] != 0 && a == 0) return 1'b0;
        if (byp[c] != 0 && win_port(c, a) >= 0) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic int exp_count(int c);
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_busy[c][r]);
        return n;
    endfunction

    // Model state update at each rising edge.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < NREG; r++) begin
                    m_regs[c][r] = '0;
                    m_busy[c][r] = 1'b0;
                end
            m_valid = 1'b1;
        end else begin
            for (int c = 0; c < 2; c++) begin
                int p [NREG];
                for (int r = 0; r < NREG; r++) p[r] = win_port(c, AW'(r));
                for (int r = 0; r < NREG; r++) begin
                    if (p[r] >= 0) m_regs[c][r] = wdata[p[r]*XLEN +: XLEN];
                    if (flush) m_busy[c][r] = 1'b0;
                    else if (rsv_valid && rsv_addr == AW'(r) && !(zr[c] != 0 && r == 0)) m_busy[c][r] = 1'b1;
                    else if (p[r] >= 0) m_busy[c][r] = 1'b0;
                end
            end
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < NRD; i++) begin
                    check($sformatf("c%0d rdata%0d", c, i), rdata[c][i*XLEN +: XLEN], exp_rdata(c, i));
                    check($sformatf("c%0d rbusy%0d", c, i), 32'(rbusy[c][i]), 32'(exp_rbusy(c, i)));
                end
                check($sformatf("c%0d rsv_conflict", c), 32'(rsv_conflict[c]),
                      32'(rsv_valid && m_busy[c][rsv_addr]));
                check($sformatf("c%0d busy_count", c), 32'(busy_count[c]), exp_count(c));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_w(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we[j] = 1'b1;
        waddr[j*AW +: AW] = a;
        wdata[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_r(input int i, input logic [AW-1:0] a);
        raddr[i*AW +: AW] = a;
    endtask

    task automatic rsv(input logic [AW-1:0] a);
        rsv_valid = 1'b1;
        rsv_addr = a;
    endtask

    function automatic logic [XLEN-1:0] rd(int c, int i);
        return rdata[c][i*XLEN +: XLEN];
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        logic [31:0] v;
        v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1);
        return v[AW-1:0];
    endfunction

    initial begin
        rstn = 1'b0; raddr = '0; idle();
        tick();
        rstn = 1'b1;

        // Reset and zero register
        idle(); set_w(0, 0, 32'hDEADBEEF); set_w(1, 5, 32'hDEADBEEF);
        tick();
        idle(); set_r(0, 0); set_r(1, 5); settle();
        check("int_r0_zero", rd(0, 0), 32'h0);
        check("int_r5_wr", rd(0, 1), 32'hDEADBEEF);
        check("fp_r0_wr", rd(1, 0), 32'hDEADBEEF);
        rstn = 1'b0; set_w(0, 5, 32'h55);
        tick();
        rstn = 1'b1; idle(); set_w(0, 0, 32'hDEADBEEF); settle();
        check("rst_int_r5", rd(0, 1), 32'h0);
        check("rst_fp_r0", rd(1, 0), 32'h0);
        check("rst_count", 32'(busy_count[0]), 32'h0);
        check("zero_no_byp", rd(0, 0), 32'h0);
        tick();
        idle(); settle();
        check("zero_wr_ignored", rd(0, 0), 32'h0);
        check("fp_r0_after_rst", rd(1, 0), 32'hDEADBEEF);

        // Bypass
        idle(); set_w(0, 7, 32'h12345678); set_r(0, 7); settle();
        check("byp_data", rd(0, 0), 32'h12345678);
        check("byp_busy", 32'(rbusy[0][0]), 32'h0);
        check("nobyp_old", rd(1, 0), 32'h0);
        tick();
        idle(); settle();
        check("nobyp_new", rd(1, 0), 32'h12345678);

        // Write-port collision
        idle(); set_w(0, 3, 32'h11); set_w(1, 3, 32'h22); set_r(0, 3); settle();
        check("coll_byp", rd(0, 0), 32'h22);
        tick();
        idle(); settle();
        check("coll_int", rd(0, 0), 32'h22);
        check("coll_fp", rd(1, 0), 32'h22);

        // Scoreboard reserve / conflict / writeback
        idle(); rsv(9); set_r(0, 9); settle();
        check("rsv_first_conf", 32'(rsv_conflict[0]), 32'h0);
        check("rsv_first_busy", 32'(rbusy[0][0]), 32'h0);
        tick();
        settle();
        check("rsv9_busy", 32'(rbusy[0][0]), 32'h1);
        check("rsv9_count", 32'(busy_count[0]), 32'h1);
        check("rsv9_conflict", 32'(rsv_conflict[0]), 32'h1);
        tick();
        idle(); set_w(0, 9, 32'h99); settle();
        check("wb_byp_busy", 32'(rbusy[0][0]), 32'h0);
        check("wb_nobyp_busy", 32'(rbusy[1][0]), 32'h1);
        check("wb_count_pre", 32'(busy_count[0]), 32'h1);
        tick();
        idle(); settle();
        check("wb_count_int", 32'(busy_count[0]), 32'h0);
        check("wb_count_fp", 32'(busy_count[1]), 32'h0);

        // Reserve and writeback on the same register in the same cycle
        idle(); rsv(4); set_w(1, 4, 32'h44);
        tick();
        idle(); set_r(0, 4); settle();
        check("rw4_data", rd(0, 0), 32'h44);
        check("rw4_busy", 32'(rbusy[0][0]), 32'h1);
        check("rw4_count", 32'(busy_count[0]), 32'h1);
        tick();
        idle(); set_w(0, 4, 32'h45);
        tick();

        // Reserving register 0
        idle(); rsv(0);
        tick();
        settle();
        check("r0_conf_int", 32'(rsv_conflict[0]), 32'h0);
        check("r0_conf_fp", 32'(rsv_conflict[1]), 32'h1);
        check("r0_count_int", 32'(busy_count[0]), 32'h0);
        check("r0_count_fp", 32'(busy_count[1]), 32'h1);
        tick();
        idle(); set_w(0, 0, 32'h0);
        tick();

        // Flush drops all reservations, including a simultaneous one
        idle(); rsv(1);
        tick();
        rsv(2);
        tick();
        rsv(3); settle();
        check("pre_flush_cnt2", 32'(busy_count[0]), 32'h2);
        tick();
        idle(); flush = 1'b1; rsv(6); set_w(0, 1, 32'hAB); settle();
        check("pre_flush_cnt3", 32'(busy_count[0]), 32'h3);
        tick();
        idle(); set_r(0, 6); set_r(1, 1); settle();
        check("flush_count", 32'(busy_count[0]), 32'h0);
        check("flush_r6_busy", 32'(rbusy[0][0]), 32'h0);
        check("flush_r1_busy", 32'(rbusy[0][1]), 32'h0);
        check("flush_wr_data", rd(0, 1), 32'hAB);
        check("flush_count_fp", 32'(busy_count[1]), 32'h0);
        tick();

        // Randomised regression
        for (int n = 0; n < 10000; n++) begin
            rstn      = ($urandom_range(0, 299) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rsv_valid = ($urandom_range(0, 9) < 4);
            rsv_addr  = pick_addr();
            for (int j = 0; j < NWR; j++) begin
                we[j] = ($urandom_range(0, 9) < 3);
                waddr[j*AW +: AW] = pick_addr();
                wdata[j*XLEN +: XLEN] = $urandom();
            end
            for (int i = 0; i < NRD; i++) set_r(i, pick_addr());
            tick();
        end

        rstn = 1'b1; idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
